// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: shared state encoding and response constants for the
// AXI4-Lite SRAM slave (optional feature macro: MEM_RANGE_CHECK_EN).
package axi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_DATA,
        WR_WAIT,
        WR_RESP
    } state_t;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [31:0] DEADBEEF_FILL = 32'hDEADBEEF;

    // True when any byte-address bit above the array's span is set.
    function automatic logic addr_out_of_range(
        input logic [31:0] addr,
        input int unsigned aw
    );
        return (addr >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/sram_bytewrite.sv
// sram_bytewrite: 32-bit word array,
// byte-lane writes, registered read.
module sram_bytewrite #(
  parameter int ADDR_W    = 12,
  parameter     INIT_FILE = ""
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][8*i +: 8] <=
            i_wdata[8*i +: 8];
        end
      end
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave: AXI4-Lite memory slave, one transaction at a time,
// programmable latency. Define MEM_RANGE_CHECK_EN for SLVERR on bad addresses.
module axi_lite_sram_slave
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int LATENCY   = 1,
    parameter     INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] AWdata,
    input  logic [2:0]  awprot,
    input  logic        AWvalid,
    output logic        AWready,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    input  logic        Wvalid,
    output logic        Wready,
    output logic        Bvalid,
    input  logic        Bready,
    input  logic [31:0] ARdata,
    input  logic [2:0]  arprot,
    input  logic        ARvalid,
    output logic        ARready,
    output logic [31:0] Rdata_mem,
    output logic        Rvalid,
    input  logic        RReady
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic [1:0]  Rresp,
    output logic [1:0]  Bresp
`endif
);

    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_awready;
    logic                r_wready;
    logic                r_bvalid;
    logic                r_arready;
    logic                r_rvalid;
    logic [31:0]         r_rdata;
    logic                w_we;
    logic [31:0]         w_rdata;
    logic                w_unused;
`ifdef MEM_RANGE_CHECK_EN
    logic                r_oor;
    logic [1:0]          r_rresp;
    logic [1:0]          r_bresp;
`endif

    // Address low bits are lane offsets and protection is informational
    assign w_unused = ^{awprot, arprot, AWdata, ARdata};

    assign AWready   = r_awready;
    assign Wready    = r_wready;
    assign Bvalid    = r_bvalid;
    assign ARready   = r_arready;
    assign Rvalid    = r_rvalid;
    assign Rdata_mem = r_rdata;
`ifdef MEM_RANGE_CHECK_EN
    assign Rresp     = r_rresp;
    assign Bresp     = r_bresp;
`endif

    // Array write fires on the W handshake, never while reset is asserted
    always_comb begin
        w_we = resetn && (r_state == WR_DATA) && r_wready && Wvalid;
`ifdef MEM_RANGE_CHECK_EN
        w_we = w_we && !r_oor;
`endif
    end

    sram_bytewrite #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clock   (clock),
        .i_addr  (r_idx),
        .i_we    (w_we),
        .i_be    (Wstrb),
        .i_wdata (Wdata),
        .o_rdata (w_rdata)
    );

    // Transaction FSM: arbitration, latency timing and registered handshakes
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
`ifdef MEM_RANGE_CHECK_EN
            r_oor     <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_bresp   <= RESP_OKAY;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (ARvalid) begin
                        r_arready <= 1'b1;
                        r_idx     <= ARdata[ADDR_W+1:2];
`ifdef MEM_RANGE_CHECK_EN
                        r_oor     <= addr_out_of_range(ARdata, ADDR_W);
`endif
                        r_state   <= RD_WAIT;
                    end else if (AWvalid) begin
                        r_awready <= 1'b1;
                        r_idx     <= AWdata[ADDR_W+1:2];
`ifdef MEM_RANGE_CHECK_EN
                        r_oor     <= addr_out_of_range(AWdata, ADDR_W);
`endif
                        r_state   <= WR_DATA;
                    end
                end
                RD_WAIT: begin
                    if (r_arready) begin
                        r_arready <= 1'b0;
                        r_cnt     <= 4'd0;
                    end else if (r_cnt == LAST) begin
`ifdef MEM_RANGE_CHECK_EN
                        r_rdata   <= r_oor ? DEADBEEF_FILL : w_rdata;
                        r_rresp   <= r_oor ? RESP_SLVERR : RESP_OKAY;
`else
                        r_rdata   <= w_rdata;
`endif
                        r_rvalid  <= 1'b1;
                        r_state   <= RD_RESP;
                    end else begin
                        r_cnt     <= r_cnt + 4'd1;
                    end
                end
                RD_RESP: begin
                    if (RReady) begin
                        r_rvalid  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                WR_DATA: begin
                    if (r_awready) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end else if (r_wready && Wvalid) begin
                        r_wready  <= 1'b0;
                        r_cnt     <= 4'd0;
                        r_state   <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (r_cnt == LAST) begin
`ifdef MEM_RANGE_CHECK_EN
                        r_bresp   <= r_oor ? RESP_SLVERR : RESP_OKAY;
`endif
                        r_bvalid  <= 1'b1;
                        r_state   <= WR_RESP;
                    end else begin
                        r_cnt     <= r_cnt + 4'd1;
                    end
                end
                WR_RESP: begin
                    if (Bready) begin
                        r_bvalid  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// tb_axi_lite_sram_slave: randomized scoreboard bench for the AXI-Lite
// SRAM slave; honours MEM_RANGE_CHECK_EN when defined.
module tb_axi_lite_sram_slave;

    localparam int LAT = 4;
`ifdef MEM_RANGE_CHECK_EN
    localparam int AW = 4;
`else
    localparam int AW = 6;
`endif
    localparam int DEPTH = 1 << AW;
    localparam int BOUND = 64;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] AWdata = '0;
    logic [2:0]  awprot = '0;
    logic        AWvalid = 1'b0;
    logic        AWready;
    logic [31:0] Wdata = '0;
    logic [3:0]  Wstrb = '0;
    logic        Wvalid = 1'b0;
    logic        Wready;
    logic        Bvalid;
    logic        Bready = 1'b0;
    logic [31:0] ARdata = '0;
    logic [2:0]  arprot = '0;
    logic        ARvalid = 1'b0;
    logic        ARready;
    logic [31:0] Rdata_mem;
    logic        Rvalid;
    logic        RReady = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    logic [1:0]  Rresp;
    logic [1:0]  Bresp;
`endif

    always #5 clock = ~clock;

    axi_lite_sram_slave #(
        .ADDR_W  (AW),
        .LATENCY (LAT)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .AWdata    (AWdata),
        .awprot    (awprot),
        .AWvalid   (AWvalid),
        .AWready   (AWready),
        .Wdata     (Wdata),
        .Wstrb     (Wstrb),
        .Wvalid    (Wvalid),
        .Wready    (Wready),
        .Bvalid    (Bvalid),
        .Bready    (Bready),
        .ARdata    (ARdata),
        .arprot    (arprot),
        .ARvalid   (ARvalid),
        .ARready   (ARready),
        .Rdata_mem (Rdata_mem),
        .Rvalid    (Rvalid),
        .RReady    (RReady)
`ifdef MEM_RANGE_CHECK_EN
        ,
        .Rresp     (Rresp),
        .Bresp     (Bresp)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic [31:0] model [DEPTH];
    exp_t        rq [$];
    logic [1:0]  bq [$];

    function automatic bit oor(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return (a / (DEPTH * 4)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic seen(input string name, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got timeout expected handshake", name);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a, input int stall,
                           input bit pre);
        exp_t e;
        int   n;
        e.data = oor(a) ? 32'hDEADBEEF : model[widx(a)];
        e.resp = oor(a) ? 2'b10 : 2'b00;
        rq.push_back(e);
        ARdata  = a;
        arprot  = 3'($urandom);
        ARvalid = 1'b1;
        RReady  = pre;
        n = 0;
        while (!ARready && n < BOUND) begin tick; n++; end
        seen("ar_accept", ARready);
        tick;
        ARvalid = 1'b0;
        n = 0;
        while (!Rvalid && n < BOUND) begin tick; n++; end
        seen("r_valid", Rvalid);
        if (!pre) begin
            repeat (stall) tick;
            RReady = 1'b1;
        end
        tick;
        RReady = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int wdly,
                            input int bstall);
        int n;
        AWdata  = a;
        awprot  = 3'($urandom);
        AWvalid = 1'b1;
        if (wdly == 0) begin
            Wdata = d; Wstrb = s; Wvalid = 1'b1;
        end
        n = 0;
        while (!AWready && n < BOUND) begin tick; n++; end
        seen("aw_accept", AWready);
        tick;
        AWvalid = 1'b0;
        if (wdly != 0) begin
            repeat (wdly - 1) tick;
            Wdata = d; Wstrb = s; Wvalid = 1'b1;
        end
        n = 0;
        while (!Wready && n < BOUND) begin tick; n++; end
        seen("w_accept", Wready);
        if (!oor(a)) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
            end
        end
        bq.push_back(oor(a) ? 2'b10 : 2'b00);
        tick;
        Wvalid = 1'b0;
        n = 0;
        while (!Bvalid && n < BOUND) begin tick; n++; end
        seen("b_valid", Bvalid);
        repeat (bstall) tick;
        Bready = 1'b1;
        tick;
        Bready = 1'b0;
    endtask

    task automatic abort_write(input logic [31:0] a, input logic [31:0] d);
        int n;
        AWdata  = a;
        AWvalid = 1'b1;
        n = 0;
        while (!AWready && n < BOUND) begin tick; n++; end
        seen("abort_aw_accept", AWready);
        tick;
        AWvalid = 1'b0;
        Wdata   = d;
        Wstrb   = 4'hF;
        Wvalid  = 1'b1;
        resetn  = 1'b0;
        tick;
        tick;
        Wvalid  = 1'b0;
        chk("abort_wready", 32'(Wready), 32'd0);
        chk("abort_rdata", Rdata_mem, 32'd0);
        resetn  = 1'b1;
        tick;
    endtask

    int          cyc = 0;
    int          rd_t = -1;
    int          wr_t = -1;
    bit          busy = 1'b0;
    bit          aw_phase = 1'b0;
    bit          p_rvalid = 1'b0;
    bit          p_rready = 1'b0;
    bit          p_bvalid = 1'b0;
    logic [31:0] p_rdata = '0;

    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (!resetn) begin
            busy = 0; aw_phase = 0; rd_t = -1; wr_t = -1;
            p_rvalid = 0; p_rready = 0; p_bvalid = 0;
        end else begin
            if (ARready || AWready) begin
                chk("accept_when_idle", 32'(busy), 32'd0);
                busy = 1;
            end
            if (AWready) chk("read_priority", 32'(ARvalid), 32'd0);
            if (ARvalid && ARready) rd_t = cyc;
            if (AWvalid && AWready) aw_phase = 1;
            if (Wready) chk("wready_after_aw", 32'(aw_phase), 32'd1);
            if (Wvalid && Wready) begin
                wr_t = cyc;
                aw_phase = 0;
            end
            if (Rvalid && !p_rvalid)
                chk("r_latency", 32'(cyc - rd_t), 32'(LAT + 1));
            if (Rvalid && p_rvalid && !p_rready)
                chk("r_hold", Rdata_mem, p_rdata);
            if (Rvalid && RReady) begin
                busy = 0;
                if (rq.size() == 0) begin
                    chk("r_unexpected", 32'd1, 32'd0);
                end else begin
                    e = rq.pop_front();
                    chk("rdata", Rdata_mem, e.data);
`ifdef MEM_RANGE_CHECK_EN
                    chk("rresp", 32'(Rresp), 32'(e.resp));
`endif
                end
            end
            if (Bvalid && !p_bvalid)
                chk("b_latency", 32'(cyc - wr_t), 32'(LAT + 1));
            if (Bvalid && Bready) begin
                busy = 0;
                chk("b_expected", 32'(bq.size() != 0), 32'd1);
                if (bq.size() != 0) begin
`ifdef MEM_RANGE_CHECK_EN
                    chk("bresp", 32'(Bresp), 32'(bq[0]));
`endif
                    void'(bq.pop_front());
                end
            end
            p_rvalid = Rvalid;
            p_rready = RReady;
            p_bvalid = Bvalid;
            p_rdata  = Rdata_mem;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] keep;

        resetn  = 1'b0;
        AWvalid = 1'b1; Wvalid = 1'b1; ARvalid = 1'b1;
        RReady  = 1'b1; Bready = 1'b1;
        repeat (3) tick;
        chk("rst_awready", 32'(AWready), 32'd0);
        chk("rst_wready", 32'(Wready), 32'd0);
        chk("rst_bvalid", 32'(Bvalid), 32'd0);
        chk("rst_arready", 32'(ARready), 32'd0);
        chk("rst_rvalid", 32'(Rvalid), 32'd0);
        chk("rst_rdata", Rdata_mem, 32'd0);
        AWvalid = 1'b0; Wvalid = 1'b0; ARvalid = 1'b0;
        RReady  = 1'b0; Bready = 1'b0;
        resetn  = 1'b1;
        tick;

        for (int i = 0; i < DEPTH; i++)
            do_write(32'(i * 4), $urandom, 4'hF,
                     $urandom_range(0, 2), $urandom_range(0, 2));

        do_write(32'h10, 32'hA5A51234, 4'b1111, 1, 0);
        do_read(32'h10, 0, 0);
        do_write(32'h10, 32'h00EE0000, 4'b0100, 0, 1);
        do_read(32'h10, 0, 1);
        do_write(32'h10, 32'hFFFFFFFF, 4'b0000, 2, 0);
        do_read(32'h10, 1, 0);

        fork
            do_read(32'h10, 2, 0);
            do_write(32'h10, 32'h11223344, 4'b1111, 0, 0);
        join
        do_read(32'h10, 0, 0);

        do_read(32'h14, 5, 0);

        keep = model[widx(32'h18)];
        abort_write(32'h18, ~keep);
        do_read(32'h18, 0, 0);

`ifdef MEM_RANGE_CHECK_EN
        do_write(32'h100, 32'h12345678, 4'hF, 1, 0);
        do_read(32'h100, 0, 0);
        do_read(32'h0, 0, 0);
`else
        do_write(32'((DEPTH * 4) + 32'h20), 32'hCAFEF00D, 4'hF, 1, 0);
        do_read(32'h20, 0, 0);
`endif

        for (int k = 0; k < 300; k++) begin
            a = $urandom;
`ifdef MEM_RANGE_CHECK_EN
            if ($urandom_range(0, 3) != 0) a = a % (DEPTH * 4);
`endif
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 5), 1'($urandom));
        end

        repeat (4) tick;
        chk("rq_drained", 32'(rq.size()), 32'd0);
        chk("bq_drained", 32'(bq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
